sipo_rx_ctrl: RTL and testbench
===============================

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame; legal range 2..16.
REQ-002 Parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 serial_in  input  1  serial line, one bit per clk; idles high; already synchronous to clk.
REQ-006 clr_status  input  1  synchronous clear of the sticky status flags.
REQ-007 data_out  output  DATA_W  received word, held stable while data_valid=1.
REQ-008 data_perr  output  1  parity-error sideband qualified by data_valid; always 0 when PARITY_EN=0.
REQ-009 data_valid  output  1  output holding register is full.
REQ-010 data_ready  input  1  consumer accepts; transfer occurs on a cycle where data_valid=1 and data_ready=1.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 overflow  output  1  sticky: a good frame was dropped because the holding register was full.
REQ-013 frame_err  output  1  sticky: a stop bit was sampled as 0.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SHIFT, PARITY, STOP and BREAK.
REQ-015 IDLE: serial_in=0 at an edge SHALL be taken as the start bit -> SHIFT, bit counter=0; serial_in=1 -> remain in IDLE.
REQ-016 SHIFT: each cycle SHALL shift serial_in into the LSB of the internal shift register ({sr[DATA_W-2:0], serial_in}, first bit becomes MSB) and increment the bit counter.
REQ-017 After DATA_W samples in SHIFT -> PARITY if PARITY_EN=1, else -> STOP; the counter width SHALL cover DATA_W without wrap.
REQ-018 PARITY: sample serial_in once; the parity error bit = XOR of the data bits XOR the sampled bit (1 means error) -> STOP.
REQ-019 STOP, serial_in=1: good frame -> IDLE; SHALL load data_out/data_perr and set data_valid at that edge if the holding register is empty or is being consumed in the same cycle.
REQ-020 STOP, serial_in=1, holding register full and not consumed that cycle: SHALL drop the frame, set overflow, and leave data_out/data_perr unchanged.
REQ-021 STOP, serial_in=0: SHALL drop the frame, set frame_err -> BREAK.
REQ-022 BREAK: remain until serial_in=1, then -> IDLE; a low line in BREAK SHALL NOT start a frame.
REQ-023 Latency: data_valid SHALL rise on the edge that samples the stop bit; a frame occupies 1+DATA_W+PARITY_EN+1 cycles.
REQ-024 Back-to-back frames: a start bit SHALL be accepted in the cycle immediately after the STOP cycle.
REQ-025 Handshake: data_valid SHALL clear on a transfer unless a new word loads on the same edge, in which case data_valid stays 1 with the new word and no overflow.
REQ-026 data_out SHALL NOT change while data_valid=1 and data_ready=0.
REQ-027 clr_status SHALL clear overflow and frame_err; a set event in the same cycle SHALL take priority (flag reads 1).
REQ-028 data_ready SHALL have no effect on the FSM; reception never stalls.

Reset
REQ-029 rst=1 SHALL immediately force: FSM=IDLE, bit counter=0, shift register=0, data_out=0, data_perr=0, data_valid=0, busy=0, overflow=0, frame_err=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the first serial_in=0 seen in IDLE starts a new frame.

Verification
REQ-031 Good frame: DATA_W=8, PARITY_EN=1, data_ready=1, line 0,1,0,1,0,0,1,0,1,0,1 -> data_out=0xA5, data_perr=0, data_valid=1 for exactly one cycle, starting at the stop-bit edge.
REQ-032 Parity error: same frame with parity bit=1 -> data_out=0xA5, data_perr=1, overflow=0, frame_err=0.
REQ-033 Bad stop: frame 0x3C, correct parity, stop=0, then line held low 3 cycles -> no data_valid, frame_err=1, busy=1 until the first serial_in=1, then IDLE.
REQ-034 Overflow: data_ready=0, frames 0x11 then 0x22 back-to-back -> data_out=0x11, overflow=1; raise data_ready -> one transfer of 0x11, then data_valid=0; clr_status -> overflow=0.
REQ-035 Simultaneous: data_valid=1 holding 0x11, data_ready=1 on the stop edge of frame 0x22 -> data_valid stays 1, data_out=0x22, overflow=0.
REQ-036 Reset mid-frame: rst pulsed after 4 data bits -> all outputs 0; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - serial-in parallel-out frame receiver with holding register and sticky status
module sipo_rx_ctrl #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              clr_status,
  output logic [DATA_W-1:0] data_out,
  output logic              data_perr,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              fperr_q, fperr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dperr_q, dperr_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;
  logic              good_stop, bad_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      fperr_q <= 1'b0;
      dout_q  <= '0;
      dperr_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      fperr_q <= fperr_d;
      dout_q  <= dout_d;
      dperr_q <= dperr_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    fperr_d   = fperr_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!serial_in) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        sr_d  = {sr_q[DATA_W-2:0], serial_in};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        fperr_d = (^sr_q) ^ serial_in;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (serial_in) begin
          good_stop = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          bad_stop = 1'b1;
          state_d  = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (serial_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed frame may load into the holding register on the same edge it is drained.
  always_comb begin
    dout_d  = dout_q;
    dperr_d = dperr_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
    if (good_stop && (!valid_q || data_ready)) begin
      dout_d  = sr_q;
      dperr_d = PARITY_EN ? fperr_q : 1'b0;
      valid_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (good_stop && valid_q && !data_ready) begin
      ovf_d = 1'b1;
    end else if (clr_status) begin
      ovf_d = 1'b0;
    end
    if (bad_stop) begin
      ferr_d = 1'b1;
    end else if (clr_status) begin
      ferr_d = 1'b0;
    end
  end

  assign data_out   = dout_q;
  assign data_perr  = dperr_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb/tb_sipo_rx_ctrl.sv - self-checking bench for sipo_rx_ctrl (DATA_W=8, even parity)
module tb_sipo_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       clr_status = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_perr, data_valid, busy, overflow, frame_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .clr_status (clr_status),
    .data_out   (data_out),
    .data_perr  (data_perr),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic rdy_stop);
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(pbit);
    data_ready = rdy_stop;
    drive_bit(sbit);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbad;
    logic       stop;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic       sin;
    logic       good;
    logic       bad;
    logic       busy;
    logic [7:0] d;
    logic       pe;
  } cyc_t;

  vec_t vecs[6];
  cyc_t cq[$];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    #1;
    check("reset data_out", data_out, 8'h00);
    check("reset valid", data_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset flags", {overflow, frame_err, data_perr}, 3'b000);
    #12 rst = 1'b0;
    @(posedge clk); #1;
    drive_bit(1'b0);
    check("idle low starts frame", busy, 1'b1);
    rst = 1'b1; #1; rst = 1'b0;
    drive_bit(1'b1);
    check("idle high stays idle", busy, 1'b0);

    // Table frames with consumer always ready
    data_ready = 1'b1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, (^vecs[k].data) ^ vecs[k].pbad, vecs[k].stop, 1'b1);
      check($sformatf("vec%0d valid", k), data_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d frame_err", k), frame_err, vecs[k].exp_ferr);
      check($sformatf("vec%0d overflow", k), overflow, 1'b0);
      if (vecs[k].exp_valid) begin
        check($sformatf("vec%0d data", k), data_out, vecs[k].data);
        check($sformatf("vec%0d perr", k), data_perr, vecs[k].exp_perr);
        drive_bit(1'b1);
        check($sformatf("vec%0d valid one cycle", k), data_valid, 1'b0);
      end else begin
        for (int j = 0; j < 3; j++) begin
          drive_bit(1'b0);
          check($sformatf("vec%0d break busy", k), busy, 1'b1);
          check($sformatf("vec%0d break no valid", k), data_valid, 1'b0);
        end
        drive_bit(1'b1);
        check($sformatf("vec%0d break exit", k), busy, 1'b0);
      end
      clr_status = 1'b1;
      drive_bit(1'b1);
      clr_status = 1'b0;
      check($sformatf("vec%0d clr", k), {overflow, frame_err}, 2'b00);
    end

    // Overflow with back-to-back frames
    data_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
    check("ovf first valid", data_valid, 1'b1);
    check("ovf first data", data_out, 8'h11);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0);
    check("ovf data held", data_out, 8'h11);
    check("ovf flag", overflow, 1'b1);
    check("ovf valid held", data_valid, 1'b1);
    data_ready = 1'b1;
    drive_bit(1'b1);
    check("ovf drained", data_valid, 1'b0);
    data_ready = 1'b0;
    clr_status = 1'b1;
    drive_bit(1'b1);
    clr_status = 1'b0;
    check("ovf cleared", overflow, 1'b0);

    // Load and drain on the same edge
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
    check("sim first data", data_out, 8'h11);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b1);
    data_ready = 1'b0;
    check("sim valid", data_valid, 1'b1);
    check("sim data", data_out, 8'h22);
    check("sim no ovf", overflow, 1'b0);

    // Clear and set on the same edge: set wins
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
    check("ferr set", frame_err, 1'b1);
    clr_status = 1'b1;
    drive_bit(1'b1);
    clr_status = 1'b0;
    check("ferr cleared", frame_err, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(1'b0);
    drive_bit(1'b0);
    clr_status = 1'b1;
    drive_bit(1'b0);
    clr_status = 1'b0;
    check("ferr set beats clr", frame_err, 1'b1);
    drive_bit(1'b1);

    // Reset mid-frame
    drive_bit(1'b0);
    for (int i = 7; i >= 4; i--) drive_bit(8'h5A >> i);
    rst = 1'b1;
    serial_in = 1'b1;
    #1;
    check("midrst outputs", {data_out, data_valid, data_perr, busy, overflow, frame_err}, 13'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    data_ready = 1'b1;
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b1);
    check("midrst next valid", data_valid, 1'b1);
    check("midrst next data", data_out, 8'h5A);
    check("midrst next perr", data_perr, 1'b0);
    drive_bit(1'b1);

    // Random frames against a frame-level reference model
    rst = 1'b1; #1; rst = 1'b0;
    for (int f = 0; f < 60; f++) begin
      logic [7:0] d;
      logic       flip, sbad;
      int         gap;
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 7) == 0);
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0});
      cq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 1'b0});
      for (int i = 7; i >= 0; i--) cq.push_back('{d[i], 1'b0, 1'b0, 1'b1, 8'h0, 1'b0});
      cq.push_back('{(^d) ^ flip, 1'b0, 1'b0, 1'b1, 8'h0, 1'b0});
      if (!sbad) begin
        cq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, d, flip});
      end else begin
        cq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 1'b0});
        for (int j = 0; j < int'($urandom_range(0, 3)); j++)
          cq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 1'b0});
        cq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0});
      end
    end
    begin
      logic       mv = 1'b0, movf = 1'b0, mferr = 1'b0, mp = 1'b0;
      logic [7:0] md = 8'h0;
      logic       r, c;
      while (cq.size() > 0) begin
        cyc_t e;
        e = cq.pop_front();
        r = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 7) == 0);
        serial_in  = e.sin;
        data_ready = r;
        clr_status = c;
        @(posedge clk); #1;
        if (e.good && mv && !r) movf = 1'b1;
        else if (c) movf = 1'b0;
        if (e.bad) mferr = 1'b1;
        else if (c) mferr = 1'b0;
        if (e.good && (!mv || r)) begin
          mv = 1'b1; md = e.d; mp = e.pe;
        end else if (mv && r) begin
          mv = 1'b0;
        end
        check("rnd valid", data_valid, mv);
        check("rnd busy", busy, e.busy);
        check("rnd overflow", overflow, movf);
        check("rnd frame_err", frame_err, mferr);
        if (mv) begin
          check("rnd data", data_out, md);
          check("rnd perr", data_perr, mp);
        end
      end
    end
    clr_status = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
